// File: rtl/crc_engine_if.sv
// ---------------------------------------------------------------------------
// crc_engine_if
// Byte-stream handshake and result bundle for crc_engine.
//   din        : data byte from the source
//   din_valid  : byte present on din
//   din_sof    : first byte of a frame (engine reloads its preset)
//   din_last   : last byte of a frame (engine publishes the result)
//   din_ready  : engine can accept a byte this cycle
//   crc_out    : final CRC of the last completed frame
//   crc_valid  : crc_out / crc_match are meaningful
//   crc_match  : raw register was zero at frame end (appended-CRC residue)
//   busy       : engine is folding a byte
// master = byte source / result consumer, slave = the engine.
// ---------------------------------------------------------------------------
interface crc_engine_if #(
  parameter int CRC_W = 16
);
  logic [7:0]       din;
  logic             din_valid;
  logic             din_sof;
  logic             din_last;
  logic             din_ready;
  logic [CRC_W-1:0] crc_out;
  logic             crc_valid;
  logic             crc_match;
  logic             busy;

  modport master (
    output din, din_valid, din_sof, din_last,
    input  din_ready, crc_out, crc_valid, crc_match, busy
  );

  modport slave (
    input  din, din_valid, din_sof, din_last,
    output din_ready, crc_out, crc_valid, crc_match, busy
  );
endinterface

// File: rtl/crc_engine.sv
// ---------------------------------------------------------------------------
// crc_engine
// Parametrised CRC generator/checker over a byte stream. Each accepted byte
// is XORed into the raw register and then folded BITS_PER_CLK bits per
// cycle, so one byte takes N = 8/BITS_PER_CLK busy cycles.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous abort/clear, dominant over the byte handshake
//   bus    : crc_engine_if.slave (byte handshake in, CRC result out)
// ---------------------------------------------------------------------------
module crc_engine #(
  parameter int               CRC_W        = 16,
  parameter logic [CRC_W-1:0] POLY         = 16'h8005,
  parameter logic [CRC_W-1:0] INIT         = 16'hFFFF,
  parameter bit               REFIN        = 1'b1,
  parameter bit               REFOUT       = 1'b1,
  parameter logic [CRC_W-1:0] XOROUT       = 16'h0000,
  parameter int               BITS_PER_CLK = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  crc_engine_if.slave   bus
);

  localparam int         N        = 8 / BITS_PER_CLK;
  localparam logic [3:0] CNT_LAST = 4'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [CRC_W-1:0] reverse_w(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  // A reflected engine works on the mirrored register, so both the
  // polynomial and the preset are mirrored to match the standard CRC model.
  localparam logic [CRC_W-1:0] POLY_REV     = reverse_w(POLY);
  localparam logic [CRC_W-1:0] INIT_ALIGNED = REFIN ? reverse_w(INIT) : INIT;

  // One cycle's worth of conditional shift/XOR steps.
  function automatic logic [CRC_W-1:0] fold_bits(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = v;
    for (int i = 0; i < BITS_PER_CLK; i++) begin
      if (REFIN) r = r[0] ? ((r >> 1) ^ POLY_REV) : (r >> 1);
      else       r = r[CRC_W-1] ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  state_t           state;
  logic [CRC_W-1:0] raw;
  logic [3:0]       bit_cnt;
  logic             last_q;
  logic [CRC_W-1:0] crc_out_q;
  logic             crc_valid_q;
  logic             crc_match_q;
  logic             ready_q;
  logic             busy_q;

  logic [CRC_W-1:0] din_aligned;
  logic [CRC_W-1:0] raw_folded;
  logic [CRC_W-1:0] result_next;

  // Reflected input enters at the bottom of the register, normal at the top.
  assign din_aligned = REFIN ? CRC_W'(bus.din) : (CRC_W'(bus.din) << (CRC_W - 8));
  assign raw_folded  = fold_bits(raw);
  assign result_next = ((REFOUT != REFIN) ? reverse_w(raw_folded) : raw_folded) ^ XOROUT;

  // Control FSM; ready/busy are registered alongside the state so they
  // change exactly on the transitions into and out of SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      raw         <= INIT_ALIGNED;
      bit_cnt     <= '0;
      last_q      <= 1'b0;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
      crc_match_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else if (clr) begin
      // crc_out is deliberately held so the last result stays readable.
      state       <= IDLE;
      raw         <= INIT_ALIGNED;
      bit_cnt     <= '0;
      last_q      <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_match_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.din_valid) begin
            raw         <= (bus.din_sof ? INIT_ALIGNED : raw) ^ din_aligned;
            last_q      <= bus.din_last;
            bit_cnt     <= '0;
            crc_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          raw <= raw_folded;
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            if (last_q) begin
              crc_out_q   <= result_next;
              crc_match_q <= (raw_folded == '0);
              crc_valid_q <= 1'b1;
              state       <= DONE;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.crc_out   = crc_out_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.crc_match = crc_match_q;

endmodule

// File: tb/tb_crc_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_engine
// Twelve engines: Modbus, CCITT-FALSE and CRC-32, each at 1/2/4/8 bits per
// clock. Index idx = 4*config + log2(bits per clock). Results are compared
// with a textbook MSB-first bitwise CRC model and with published check values.
// ---------------------------------------------------------------------------
module tb_crc_engine;

  localparam int NUM = 12;

  logic clk;
  logic rst_n;
  logic clr;

  logic [7:0]       srcDin [NUM];
  logic [NUM-1:0]   srcValid, srcSof, srcLast;
  logic [NUM-1:0]   readyOut, busyOut, validOut, matchOut;
  logic [NUM-1:0][31:0] crcOut;

  int checks;
  int errors;
  int cycle;
  int acceptCycle;

  logic [31:0] modelReg [NUM];
  logic [7:0]  frameBuf [64];

  // Configuration table: 0 Modbus, 1 CCITT-FALSE, 2 CRC-32.
  function automatic int cfgW(input int c);
    return (c == 2) ? 32 : 16;
  endfunction
  function automatic logic [31:0] cfgPoly(input int c);
    case (c)
      0:       return 32'h0000_8005;
      1:       return 32'h0000_1021;
      default: return 32'h04C1_1DB7;
    endcase
  endfunction
  function automatic logic [31:0] cfgInit(input int c);
    return (c == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction
  function automatic bit cfgRef(input int c);
    return (c != 1);
  endfunction
  function automatic logic [31:0] cfgXor(input int c);
    return (c == 2) ? 32'hFFFF_FFFF : 32'h0000_0000;
  endfunction
  function automatic logic [31:0] cfgKnown(input int c);
    case (c)
      0:       return 32'h0000_4B37;
      1:       return 32'h0000_29B1;
      default: return 32'hCBF4_3926;
    endcase
  endfunction
  function automatic int nOf(input int idx);
    return 8 >> (idx % 4);
  endfunction

  // Textbook CRC: optionally mirror each byte, feed it MSB-first into an
  // unreflected register, mirror the result on output, then XOR.
  function automatic logic [31:0] reflectN(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction
  function automatic logic [31:0] maskN(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction
  function automatic logic [31:0] modelFold(input int c, input logic [31:0] r, input logic [7:0] b);
    int          w;
    logic [31:0] x;
    logic [31:0] d;
    logic        top;
    w = cfgW(c);
    d = cfgRef(c) ? reflectN({24'h0, b}, 8) : {24'h0, b};
    x = r ^ (d << (w - 8));
    for (int i = 0; i < 8; i++) begin
      top = x[w-1];
      x   = (x << 1) & maskN(w);
      if (top) x = x ^ cfgPoly(c);
    end
    return x;
  endfunction
  function automatic logic [31:0] modelOut(input int c, input logic [31:0] r);
    return (cfgRef(c) ? reflectN(r, cfgW(c)) : r) ^ cfgXor(c);
  endfunction

  // Devices under test, one per configuration and fold width.
  for (genvar g = 0; g < NUM; g++) begin : gDut
    localparam int C   = g / 4;
    localparam int W   = cfgW(C);
    localparam int BPC = 1 << (g % 4);

    crc_engine_if #(.CRC_W(W)) ifc ();

    assign ifc.din       = srcDin[g];
    assign ifc.din_valid = srcValid[g];
    assign ifc.din_sof   = srcSof[g];
    assign ifc.din_last  = srcLast[g];
    assign readyOut[g]   = ifc.din_ready;
    assign busyOut[g]    = ifc.busy;
    assign validOut[g]   = ifc.crc_valid;
    assign matchOut[g]   = ifc.crc_match;
    assign crcOut[g]     = 32'(ifc.crc_out);

    crc_engine #(
      .CRC_W(W),
      .POLY(W'(cfgPoly(C))),
      .INIT(W'(cfgInit(C))),
      .REFIN(cfgRef(C)),
      .REFOUT(cfgRef(C)),
      .XOROUT(W'(cfgXor(C))),
      .BITS_PER_CLK(BPC)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clr(clr),
      .bus(ifc.slave)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop if something stalls far beyond the expected run length.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NUM; i++) modelReg[i] = cfgInit(i / 4);
  endtask

  // Offers one byte to engine idx and returns just after it is accepted.
  // With hold set, din_valid stays high for the next byte.
  task automatic applyStimulus(input int idx, input logic [7:0] b, input bit sof,
                               input bit last, input bit hold);
    int n;
    @(negedge clk);
    srcDin[idx]   = b;
    srcSof[idx]   = sof;
    srcLast[idx]  = last;
    srcValid[idx] = 1'b1;
    n = 0;
    while (!readyOut[idx] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!readyOut[idx]) begin
      checkOutput("readyTimeout", 32'(readyOut[idx]), 32'd1);
      srcValid[idx] = 1'b0;
      return;
    end
    acceptCycle = cycle;
    @(posedge clk);
    #1;
    if (!hold) srcValid[idx] = 1'b0;
    modelReg[idx] = sof ? cfgInit(idx / 4) : modelReg[idx];
    modelReg[idx] = modelFold(idx / 4, modelReg[idx], b);
  endtask

  task automatic waitValid(input int idx, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!validOut[idx] && n < 40);
    if (!validOut[idx]) checkOutput("validTimeout", 32'(validOut[idx]), 32'd1);
  endtask

  task automatic runFrame(input int idx, input int len, input bit withSof,
                          input bit useConst, input logic [31:0] constVal, input bit dropCheck);
    int n;
    for (int i = 0; i < len; i++) begin
      applyStimulus(idx, frameBuf[i], withSof && (i == 0), i == len - 1, 1'b0);
      if (dropCheck && i == 0) begin
        @(negedge clk);
        checkOutput("validDrop", 32'(validOut[idx]), 32'd0);
      end
    end
    waitValid(idx, n);
    if (!dropCheck || len > 1) checkOutput("latency", n, nOf(idx) + 1);
    checkOutput("crc", crcOut[idx], modelOut(idx / 4, modelReg[idx]));
    checkOutput("match", 32'(matchOut[idx]), 32'(modelReg[idx] == 32'h0));
    if (useConst) checkOutput("crcKnown", crcOut[idx], constVal);
  endtask

  task automatic loadVector();
    for (int i = 0; i < 9; i++) frameBuf[i] = 8'h31 + 8'(i);
  endtask

  task automatic checkResetState(input int idx);
    checkOutput("rstReady", 32'(readyOut[idx]), 32'd1);
    checkOutput("rstBusy",  32'(busyOut[idx]),  32'd0);
    checkOutput("rstValid", 32'(validOut[idx]), 32'd0);
    checkOutput("rstMatch", 32'(matchOut[idx]), 32'd0);
    checkOutput("rstCrc",   crcOut[idx],        32'd0);
  endtask

  task automatic streamTest(input int idx);
    int prev;
    int n;
    prev = 0;
    loadVector();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(idx, frameBuf[i], i == 0, i == 8, i != 8);
      if (i > 0) checkOutput("interval", acceptCycle - prev, nOf(idx) + 1);
      prev = acceptCycle;
    end
    waitValid(idx, n);
    checkOutput("streamCrc", crcOut[idx], 32'h0000_4B37);
  endtask

  initial begin
    int len;
    checks = 0;
    errors = 0;
    cycle  = 0;
    acceptCycle = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    srcValid = '0;
    srcSof   = '0;
    srcLast  = '0;
    for (int i = 0; i < NUM; i++) srcDin[i] = 8'h00;
    resetModel();

    #12;
    checkResetState(0);
    checkResetState(11);
    @(negedge clk);
    rst_n = 1'b1;

    // Check vectors on every configuration and fold width.
    for (int idx = 0; idx < NUM; idx++) begin
      loadVector();
      runFrame(idx, 9, 1'b1, 1'b1, cfgKnown(idx / 4), 1'b0);
    end

    // Modbus frame with its CRC appended low byte first leaves a zero residue.
    for (int idx = 0; idx < 4; idx++) begin
      loadVector();
      frameBuf[9]  = 8'h37;
      frameBuf[10] = 8'h4B;
      runFrame(idx, 11, 1'b1, 1'b1, 32'h0, 1'b0);
      checkOutput("residueMatch", 32'(matchOut[idx]), 32'd1);
    end

    // Random frames, including single-byte sof+last frames.
    for (int rep = 0; rep < 3; rep++) begin
      for (int idx = 0; idx < NUM; idx++) begin
        len = (rep == 0) ? 1 : int'($urandom_range(2, 8));
        for (int i = 0; i < len; i++) frameBuf[i] = 8'($urandom);
        runFrame(idx, len, 1'b1, 1'b0, 32'h0, 1'b0);
      end
    end

    // After clr, a frame without sof must start from the preset.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clrValid", 32'(validOut[4]), 32'd0);
    checkOutput("clrHeldCrc", crcOut[4], modelOut(1, modelReg[4]));
    checkOutput("clrMatch", 32'(matchOut[4]), 32'd0);
    resetModel();
    loadVector();
    runFrame(5, 9, 1'b0, 1'b1, 32'h0000_29B1, 1'b0);

    // Back-to-back throughput with din_valid held high.
    streamTest(0);
    streamTest(3);

    // Abort in the middle of folding byte 5, then a clr racing an accept.
    loadVector();
    for (int i = 0; i < 5; i++) applyStimulus(0, frameBuf[i], i == 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("midBusy", 32'(busyOut[0]), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clrReady", 32'(readyOut[0]), 32'd1);
    checkOutput("clrValid0", 32'(validOut[0]), 32'd0);
    resetModel();
    clr = 1'b1;
    srcDin[0] = 8'h55;
    srcSof[0] = 1'b1;
    srcValid[0] = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    srcValid[0] = 1'b0;
    checkOutput("clrWins", 32'(busyOut[0]), 32'd0);
    runFrame(0, 9, 1'b1, 1'b1, 32'h0000_4B37, 1'b0);

    // New sof frame accepted straight out of DONE.
    for (int i = 0; i < 6; i++) frameBuf[i] = 8'($urandom);
    runFrame(6, 6, 1'b1, 1'b0, 32'h0, 1'b0);
    loadVector();
    runFrame(6, 9, 1'b1, 1'b1, 32'h0000_29B1, 1'b1);

    // Asynchronous reset in the middle of a frame.
    applyStimulus(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetState(0);
    checkResetState(8);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    loadVector();
    runFrame(8, 9, 1'b1, 1'b1, 32'hCBF4_3926, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
